// File: rtl/tick_timer.sv
// Programmable countdown timer over the us/ms/sec tick pulses (or raw clk_200 cycles),
// with one-shot or auto-reload operation and a saturating count of periodic expiries.
module tick_timer #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 8
) (
    input  logic              clk_200,
    input  logic              reset,
    input  logic              us_tick,
    input  logic              ms_tick,
    input  logic              sec_tick,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        tb_sel,
    input  logic [CNT_W-1:0]  load_val,
    input  logic              periodic,
    output logic              busy,
    output logic              expire,
    output logic              start_err,
    output logic [CNT_W-1:0]  remaining,
    output logic [PCNT_W-1:0] period_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [1:0]          tb_sel_q, tb_sel_nxt;
    logic [CNT_W-1:0]    load_q, load_nxt;
    logic                periodic_q, periodic_nxt;
    logic                busy_nxt, expire_nxt, start_err_nxt;
    logic [CNT_W-1:0]    remaining_nxt;
    logic [PCNT_W-1:0]   period_cnt_nxt;
    logic                sel_tick;

    // Timebase is taken from the value latched at start, not the live input.
    always_comb begin
        sel_tick = 1'b0;
        case (tb_sel_q)
            2'b00:   sel_tick = us_tick;
            2'b01:   sel_tick = ms_tick;
            2'b10:   sel_tick = sec_tick;
            default: sel_tick = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        tb_sel_nxt     = tb_sel_q;
        load_nxt       = load_q;
        periodic_nxt   = periodic_q;
        busy_nxt       = busy;
        expire_nxt     = 1'b0;
        start_err_nxt  = 1'b0;
        remaining_nxt  = remaining;
        period_cnt_nxt = period_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        tb_sel_nxt     = tb_sel;
                        load_nxt       = load_val;
                        periodic_nxt   = periodic;
                        remaining_nxt  = load_val;
                        period_cnt_nxt = '0;
                        busy_nxt       = 1'b1;
                        state_nxt      = RUN;
                    end else begin
                        start_err_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                // stop wins even over the expiring tick
                if (stop) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sel_tick) begin
                    if (remaining == CNT_W'(1)) begin
                        expire_nxt = 1'b1;
                        if (periodic_q) begin
                            remaining_nxt = load_q;
                            if (period_cnt != '1)
                                period_cnt_nxt = period_cnt + PCNT_W'(1);
                        end else begin
                            remaining_nxt = '0;
                            busy_nxt      = 1'b0;
                            state_nxt     = IDLE;
                        end
                    end else begin
                        remaining_nxt = remaining - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_200) begin
        if (reset) begin
            state      <= IDLE;
            tb_sel_q   <= '0;
            load_q     <= '0;
            periodic_q <= 1'b0;
            busy       <= 1'b0;
            expire     <= 1'b0;
            start_err  <= 1'b0;
            remaining  <= '0;
            period_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tb_sel_q   <= tb_sel_nxt;
            load_q     <= load_nxt;
            periodic_q <= periodic_nxt;
            busy       <= busy_nxt;
            expire     <= expire_nxt;
            start_err  <= start_err_nxt;
            remaining  <= remaining_nxt;
            period_cnt <= period_cnt_nxt;
        end
    end

endmodule
